// File: rtl/pwm_multi_ch.sv
// rtl/pwm_multi_ch.sv - multi-channel PWM generator with shared prescaled time base and boundary-loaded shadows
module pwm_multi_ch #(
    parameter int CH        = 4,
    parameter int R         = 8,
    parameter int TimerBits = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [CH*R-1:0]      duty,
    input  logic [R-1:0]         period,
    input  logic [TimerBits-1:0] Final_Value,
    input  logic                 mode,
    input  logic [CH-1:0]        polarity,
    input  logic                 ready,
    output logic                 done,
    output logic                 cycle_start,
    output logic [CH-1:0]        pwm_out
);

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    localparam logic [R-1:0] ONE = R'(1);

    logic [TimerBits-1:0] pre_cnt;
    logic                 tick;
    logic [R-1:0]         cnt;
    logic [R-1:0]         cnt_nxt;
    dir_t                 dir;
    dir_t                 dir_nxt;
    logic                 boundary;

    logic [R-1:0]         duty_sh [CH];
    logic [R-1:0]         period_sh;
    logic                 mode_sh;
    logic [CH-1:0]        polarity_sh;

    // Terminal value is used live; >= keeps the count from running the full range
    // if Final_Value is lowered below the current count.
    assign tick = (pre_cnt >= Final_Value);

    // Free-running prescaler producing one tick every Final_Value+1 clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Period counter state register: count value and direction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            dir <= UP;
        end else begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
        end
    end

    // Next count/direction and cycle-boundary detection for both counting modes.
    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        boundary = 1'b0;
        if (tick) begin
            if (period_sh == '0) begin
                boundary = 1'b1;
            end else if (!mode_sh) begin
                if (cnt >= period_sh) begin
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end else if (dir == UP) begin
                if (cnt >= period_sh) begin
                    // With P = 1 the down leg is empty, so the top is also the boundary.
                    if (period_sh == ONE) begin
                        boundary = 1'b1;
                    end else begin
                        dir_nxt = DOWN;
                        cnt_nxt = cnt - ONE;
                    end
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end else begin
                if (cnt <= ONE) begin
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            // Every cycle restarts at 0 counting up, which also covers a mode change.
            if (boundary) begin
                cnt_nxt = '0;
                dir_nxt = UP;
            end
        end
    end

    // Shadow registers, loaded only on a boundary tick with a pending write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                duty_sh[i] <= '0;
            end
            period_sh   <= '0;
            mode_sh     <= 1'b0;
            polarity_sh <= '0;
        end else if (boundary && ready) begin
            for (int i = 0; i < CH; i++) begin
                duty_sh[i] <= duty[i*R +: R];
            end
            period_sh   <= period;
            mode_sh     <= mode;
            polarity_sh <= polarity;
        end
    end

    // Single-clock status pulses following the boundary tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            cycle_start <= boundary;
            done        <= boundary && ready;
        end
    end

    // Registered compare per channel; output lags the counter by one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                pwm_out[i] <= polarity_sh[i] ^ (cnt < duty_sh[i]);
            end
        end
    end

endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
- Multi-channel PWM generator sharing one prescaled time base and one period counter across CH channels.
- Supports edge-aligned (sawtooth) and centre-aligned (triangle) modes, a programmable period, and per-channel duty and polarity.
- All configuration passes through shadow registers and is loaded only at a PWM cycle boundary, using a ready/done handshake.
- Sits between the control/register logic and the output pins, for motor and LED drive.

Parameters:
CH, 4, number of PWM channels
R, 8, width of the counter, period and duty values
TimerBits, 15, prescaler width

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
duty  input  CH*R  per-channel duty; channel i uses bits [i*R+R-1 : i*R]
period  input  R  counter top value P
Final_Value  input  TimerBits  prescaler terminal value; one tick every Final_Value+1 clocks
mode  input  1  0 = edge-aligned, 1 = centre-aligned
polarity  input  CH  per-channel output inversion (1 = active-low)
ready  input  1  pending configuration write; hold high until done
done  output  1  one-clk pulse; the shadow load took effect this cycle
cycle_start  output  1  one-clk pulse on every cycle boundary tick
pwm_out  output  CH  PWM outputs

Behaviour:
- Reset (asynchronous): the following are cleared.
  - Prescaler count = 0, cnt = 0, dir = up.
  - All shadows = 0: duty, period, mode, polarity.
  - pwm_out = 0, done = 0, cycle_start = 0.
- Prescaler:
  - Free-running count from 0 to Final_Value, then wraps.
  - tick = 1 for one clk when count == Final_Value.
  - Final_Value = 0 gives a tick every clk.
  - Final_Value is used live; it is not shadowed.
- Counter (advances on tick only), with P = shadow period:
  - Edge mode: cnt goes 0,1,…,P, then wraps to 0. Cycle length is P+1 ticks. The boundary is the tick where cnt == P.
  - Centre mode: cnt counts up 0..P, dir flips at P, then counts down P-1..1. The boundary is the tick where dir = down and cnt == 1, after which cnt becomes 0 and dir becomes up. Cycle length is 2P ticks.
  - P = 0, either mode: cnt stays at 0 and every tick is a boundary.
  - P = 1, centre mode: sequence 0,1,0,1; the boundary is the tick at cnt == 1. Cycle length is 2 ticks.
- Boundary tick:
  - cycle_start = 1 on the next clk.
  - If ready = 1 on that clk, load all shadows from the inputs. done = 1 on the next clk, coincident with the new cnt = 0.
  - If ready = 0, keep the old shadows. No done pulse.
  - On a mode change, cnt = 0 and dir = up.
- Compare (registered every clk): pwm_out[i] <= polarity_sh[i] XOR (cnt < duty_sh[i]).
  - Output lags cnt by 1 clk.
- Duty semantics, edge mode:
  - Active for d ticks of P+1.
  - d = 0 gives 0%.
  - d ≥ P+1 gives 100%.
- Duty semantics, centre mode:
  - Active for 2d-1 of 2P ticks, for 1 ≤ d ≤ P. The pulse is symmetric about cnt = 0.
  - d = 0 gives 0%.
  - d > P gives 100%.
- Compare arithmetic is unsigned, R-bit. There are no glitches: outputs are flops, and duty/period/polarity never change mid-cycle.
- done and cycle_start are never high for more than 1 clk. The next boundary is at least 1 tick away, so back-to-back pulses occur only when Final_Value = 0 and P = 0.
- A ready deasserted before the boundary cancels the pending write without error.
- Asserting reset_n low mid-cycle aborts immediately to the reset state. No partial shadow load occurs.

Test Plan:
1. Reset, then ready = 1 with Final_Value = 0, P = 9, mode = 0, duty ch0 = 3 / ch1 = 0 / ch2 = 10 / ch3 = 5, polarity = 0:
   - First load occurs at the cnt == 0 boundary (after 1 tick from reset), with a done pulse.
   - Thereafter ch0 is high 3 of 10 clks, ch1 always 0, ch2 always 1, ch3 high 5 of 10.
   - cycle_start pulses every 10 clks.
2. Centre mode, P = 4, duty ch0 = 2, Final_Value = 0:
   - Period is 8 clks; ch0 high 3 consecutive clks per period, centred on cnt = 0.
   - Set duty = 0, then 5: output is 0%, then 100%.
3. Prescaler: Final_Value = 3, edge mode, P = 3, duty = 2:
   - cnt advances every 4 clks; cycle is 16 clks; output high 8 clks.
   - cycle_start spacing is 16 clks.
4. Handshake:
   - Change duty mid-cycle with ready = 1: the output keeps the old duty until the boundary; done pulses exactly once, the first clk of the new cycle.
   - Drop ready before the boundary: no load and no done.
5. polarity = 4'b0101 with the scenario 1 setup: ch0 and ch2 are the inverted waveforms. Mode switch 0→1 at a boundary restarts cnt at 0 counting up.
6. Assert reset_n low mid-cycle with pwm_out = 1: all outputs go to 0 asynchronously. Restart behaves exactly as scenario 1.
